// File: rtl/program_loader.sv
// Byte-stream boot loader: frames LEN_LO, LEN_HI, 4*N data bytes and an XOR checksum
// into little-endian 32-bit instruction-memory writes, holding the CPU while loading.
module program_loader #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned CMP_W  = LEN_W + 1;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [1:0]          idx_q, idx_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [7:0]          csum_q, csum_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [LEN_W-1:0]    words_q, words_d;

    logic                xfer;
    logic [LEN_W-1:0]    len_full;
    logic [LEN_W-1:0]    words_inc;

    assign xfer      = in_valid && in_ready_q;
    assign len_full  = {in_data, len_q[7:0]};
    assign words_inc = LEN_W'(words_q + LEN_W'(1));

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= ADDR_W'(BASE_ADDR);
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
            words_q     <= words_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        word_d      = word_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_we_q ? ADDR_W'(mem_addr_q + ADDR_W'(4)) : mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        error_d     = error_q;
        words_d     = words_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_LEN0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    words_d    = '0;
                    csum_d     = '0;
                    idx_d      = '0;
                    cpu_hold_d = 1'b1;
                    mem_addr_d = ADDR_W'(BASE_ADDR);
                end
            end
            S_LEN0: begin
                if (xfer) begin
                    len_d   = {len_q[15:8], in_data};
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (xfer) begin
                    len_d = len_full;
                    if ({1'b0, len_full} > CMP_W'(DEPTH_WORDS)) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else if (len_full == '0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    // Bytes shift in from the top so byte 0 lands in bits [7:0] after four
                    word_d = {in_data, word_q[31:8]};
                    csum_d = csum_q ^ in_data;
                    idx_d  = 2'(idx_q + 2'd1);
                    if (idx_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = {in_data, word_q[31:8]};
                        words_d     = words_inc;
                        if (words_inc == len_q) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    if (in_data == csum_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                     (state_d == S_DATA) || (state_d == S_CHECK);
    end

    assign in_ready     = in_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frames are built from word lists by a
// reference model and the observed memory writes and status are compared against it.
module tb_program_loader;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned BASE  = 0;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [31:0] word_q_t[$];

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_ready, mem_we, cpu_hold, done, error;
    logic [7:0]  in_data;
    logic [31:0] mem_addr, mem_wdata;
    logic [15:0] words_loaded;

    int errors = 0;
    int checks = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          consec_viol = 0;
    logic        we_prev = 1'b0;
    word_q_t     t2_words;

    program_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            if (we_prev) consec_viol++;
        end
        we_prev = mem_we;
    end

    // Reference framing: length LE, data bytes LE per word, XOR checksum (optionally corrupted)
    function automatic byte_q_t build_frame(input word_q_t w, input int n, input bit bad);
        byte_q_t b;
        logic [7:0] cs;
        logic [31:0] x;
        cs = 8'h00;
        b.push_back(8'(n));
        b.push_back(8'(n >> 8));
        for (int k = 0; k < w.size(); k++) begin
            for (int j = 0; j < 4; j++) begin
                x = w[k] >> (8 * j);
                b.push_back(x[7:0]);
                cs = cs ^ x[7:0];
            end
        end
        b.push_back(bad ? ~cs : cs);
        return b;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic drive_bytes(input byte_q_t b, input int bubble_pct, output int cycles);
        int i;
        i = 0;
        cycles = 0;
        while (i < b.size() && cycles < 5000) begin
            @(posedge clk); #1;
            if (int'($urandom_range(99)) < bubble_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = b[i];
            end
            cycles++;
            @(negedge clk);
            if (in_valid && in_ready) i++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (i != b.size()) begin
            errors++;
            $display("FAIL drive_timeout: accepted %0d bytes, required %0d", i, b.size());
        end
    endtask

    task automatic run_frame(input word_q_t w, input int n, input bit bad, input int bubble,
                             output int cycles);
        pulse_start();
        wr_addr_q.delete();
        wr_data_q.delete();
        drive_bytes(build_frame(w, n, bad), bubble, cycles);
        tick(3);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        tick(2);
        reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, mem_we, cpu_hold, done, error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 00000", {in_ready, mem_we, cpu_hold, done, error});
        end
        checks++;
        if (mem_addr !== 32'(BASE) || mem_wdata !== 32'h0 || words_loaded !== 16'h0) begin
            errors++;
            $display("FAIL reset_regs: addr=%h wdata=%h words=%0d, required %h 0 0", mem_addr, mem_wdata, words_loaded, BASE);
        end
    endtask

    task automatic test_single_word();
        word_q_t w;
        int cyc;
        w = '{32'h0000_0013};
        run_frame(w, 1, 1'b0, 0, cyc);
        checks++;
        if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 32'(BASE) || wr_data_q[0] !== 32'h13) begin
            errors++;
            $display("FAIL single_write: count=%0d, required one write of 00000013 at %h", wr_addr_q.size(), BASE);
        end
        checks++;
        if ({done, error, cpu_hold} !== 3'b100 || words_loaded !== 16'd1) begin
            errors++;
            $display("FAIL single_status: done/err/hold=%b words=%0d, required 100 1", {done, error, cpu_hold}, words_loaded);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_frame(t2_words, 2, 1'b0, 0, cyc);
        checks++;
        if (cyc !== 11) begin
            errors++;
            $display("FAIL b2b_stall: took %0d cycles, required 11", cyc);
        end
        checks++;
        if (wr_addr_q.size() !== 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d writes, required 2", wr_addr_q.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (wr_addr_q[k] !== 32'(BASE + 4 * k) || wr_data_q[k] !== t2_words[k]) begin
                    errors++;
                    $display("FAIL b2b_write%0d: got %h@%h, required %h@%h", k, wr_data_q[k], wr_addr_q[k], t2_words[k], BASE + 4 * k);
                end
            end
        end
        checks++;
        if ({done, error, cpu_hold} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_done: done/err/hold=%b, required 100", {done, error, cpu_hold});
        end
    endtask

    task automatic test_bad_checksum();
        word_q_t w;
        int cyc;
        w = '{32'h0000_0013};
        run_frame(w, 1, 1'b1, 0, cyc);
        checks++;
        if (wr_addr_q.size() !== 1 || wr_data_q[0] !== 32'h13) begin
            errors++;
            $display("FAIL badcs_write: count=%0d, required one write of 00000013", wr_addr_q.size());
        end
        checks++;
        if ({done, error, cpu_hold} !== 3'b011) begin
            errors++;
            $display("FAIL badcs_status: done/err/hold=%b, required 011", {done, error, cpu_hold});
        end
    endtask

    task automatic test_too_long();
        byte_q_t b;
        int cyc;
        b = '{8'h01, 8'h01};
        pulse_start();
        wr_addr_q.delete();
        wr_data_q.delete();
        drive_bytes(b, 0, cyc);
        @(negedge clk);
        checks++;
        if ({error, done, in_ready} !== 3'b100) begin
            errors++;
            $display("FAIL toolong_status: err/done/ready=%b, required 100", {error, done, in_ready});
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 in_valid = 1'b1; in_data = 8'($urandom);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || error !== 1'b1) begin
                errors++;
                $display("FAIL toolong_idle%0d: ready=%b err=%b, required 0 1", i, in_ready, error);
            end
        end
        @(posedge clk); #1 in_valid = 1'b0;
        checks++;
        if (wr_addr_q.size() !== 0 || words_loaded !== 16'd0) begin
            errors++;
            $display("FAIL toolong_nowrite: writes=%0d words=%0d, required 0 0", wr_addr_q.size(), words_loaded);
        end
    endtask

    task automatic test_zero_length();
        word_q_t w;
        int cyc;
        w = {};
        run_frame(w, 0, 1'b0, 0, cyc);
        checks++;
        if ({done, error, cpu_hold} !== 3'b100 || wr_addr_q.size() !== 0) begin
            errors++;
            $display("FAIL zero_status: done/err/hold=%b writes=%0d, required 100 0", {done, error, cpu_hold}, wr_addr_q.size());
        end
        pulse_start();
        @(negedge clk);
        checks++;
        if ({in_ready, done, error, cpu_hold} !== 4'b1001) begin
            errors++;
            $display("FAIL zero_restart: ready/done/err/hold=%b, required 1001", {in_ready, done, error, cpu_hold});
        end
    endtask

    task automatic test_start_ignored();
        byte_q_t b;
        byte_q_t head;
        byte_q_t tail;
        word_q_t w;
        int cyc;
        reset = 1'b1; tick(1); reset = 1'b0;
        w = '{32'hDEAD_BEEF};
        b = build_frame(w, 1, 1'b0);
        head = b[0:3];
        tail = b[4:6];
        pulse_start();
        wr_addr_q.delete();
        wr_data_q.delete();
        drive_bytes(head, 0, cyc);
        pulse_start();
        drive_bytes(tail, 0, cyc);
        tick(3);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || wr_addr_q.size() !== 1 || wr_data_q[0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL start_ignored: done=%b writes=%0d, required done=1 one write of deadbeef", done, wr_addr_q.size());
        end
    endtask

    task automatic test_reset_midload();
        byte_q_t b;
        byte_q_t head;
        int cyc;
        b = build_frame(t2_words, 2, 1'b0);
        head = b[0:3];
        pulse_start();
        wr_addr_q.delete();
        wr_data_q.delete();
        drive_bytes(head, 0, cyc);
        reset = 1'b1; tick(1); reset = 1'b0;
        tick(4);
        @(negedge clk);
        checks++;
        if ({in_ready, cpu_hold, done, error} !== 4'b0000 || wr_addr_q.size() !== 0) begin
            errors++;
            $display("FAIL midreset: ready/hold/done/err=%b writes=%0d, required 0000 0", {in_ready, cpu_hold, done, error}, wr_addr_q.size());
        end
        run_frame(t2_words, 2, 1'b0, 40, cyc);
        checks++;
        if (wr_addr_q.size() !== 2 || wr_data_q[0] !== t2_words[0] || wr_data_q[1] !== t2_words[1] || done !== 1'b1) begin
            errors++;
            $display("FAIL midreset_reload: writes=%0d done=%b, required 2 writes matching and done=1", wr_addr_q.size(), done);
        end
    endtask

    task automatic test_random(input int iters, input int n_max, input int bubble);
        word_q_t w;
        int n, cyc;
        bit bad;
        for (int it = 0; it < iters; it++) begin
            n = (n_max == int'(DEPTH)) ? n_max : int'($urandom_range(n_max, 1));
            bad = (n_max != int'(DEPTH)) && ($urandom_range(3) == 0);
            w = {};
            for (int k = 0; k < n; k++) w.push_back($urandom);
            run_frame(w, n, bad, bubble, cyc);
            checks++;
            if (wr_addr_q.size() !== n) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d writes, required %0d", it, wr_addr_q.size(), n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    checks++;
                    if (wr_addr_q[k] !== 32'(BASE + 4 * k) || wr_data_q[k] !== w[k]) begin
                        errors++;
                        $display("FAIL rand%0d_write%0d: got %h@%h, required %h@%h", it, k, wr_data_q[k], wr_addr_q[k], w[k], BASE + 4 * k);
                    end
                end
            end
            checks++;
            if (done !== !bad || error !== bad || cpu_hold !== bad || words_loaded !== 16'(n)) begin
                errors++;
                $display("FAIL rand%0d_status: done/err/hold=%b words=%0d, required %b %0d", it, {done, error, cpu_hold}, words_loaded, {!bad, bad, bad}, n);
            end
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        t2_words = '{32'h0050_0093, 32'h00A0_0113};
        test_reset();
        test_single_word();
        test_back_to_back();
        test_bad_checksum();
        test_too_long();
        test_zero_length();
        test_start_ignored();
        test_reset_midload();
        test_random(8, 6, 30);
        test_random(1, int'(DEPTH), 0);
        checks++;
        if (consec_viol !== 0) begin
            errors++;
            $display("FAIL consecutive_we: %0d back-to-back strobes, required 0", consec_viol);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
